// File: rtl/sd_block_receiver_if.sv
// Bus between the SD data-block receiver, the SPI byte engine and the sector buffer.
// The receiver uses the slave view. The byte engine, the buffer and the controller use the master view.
interface sd_block_receiver_if;
  logic       start;
  logic       req_byte;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       crc_err;
  logic       tok_err;
  logic       timeout;

  modport slave (
    input  start, rx_valid, rx_byte,
    output req_byte, wr_en, wr_addr, wr_data, busy, done, crc_err, tok_err, timeout
  );

  modport master (
    output start, rx_valid, rx_byte,
    input  req_byte, wr_en, wr_addr, wr_data, busy, done, crc_err, tok_err, timeout
  );
endinterface

// File: rtl/sd_block_receiver.sv
// SD SPI-mode data block receiver.
// It polls for the start token, then stores BLOCK_LEN data bytes in the sector buffer.
// It then checks the trailing CRC16 and reports the result with a single done pulse.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; status flags hold the last result
// WAIT_TOKEN | polling bytes until 0xFE, an error token or poll timeout
// DATA       | each received byte goes to the buffer and into the CRC
// CRC_HI     | capturing the high byte of the card's CRC16
// CRC_LO     | capturing the low byte and comparing against computed CRC
// FINISH     | one-cycle done pulse, then back to IDLE
module sd_block_receiver #(
  parameter int BLOCK_LEN     = 512,
  parameter int TOKEN_TIMEOUT = 1023
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sd_block_receiver_if.slave   io_bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_TOKEN = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_CRC_HI     = 3'd3;
  localparam logic [2:0] S_CRC_LO     = 3'd4;
  localparam logic [2:0] S_FINISH     = 3'd5;

  localparam int         PW       = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [PW-1:0] TO_MAX = PW'(TOKEN_TIMEOUT);
  localparam logic [8:0] LAST_IDX = 9'(BLOCK_LEN - 1);

  logic [2:0]    r_state;
  logic          r_pend;
  logic [PW-1:0] r_poll;
  logic [8:0]    r_byte_cnt;
  logic [15:0]   r_crc;
  logic [7:0]    r_crc_hi;
  logic          r_req;
  logic          r_wr_en;
  logic [8:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_crc_err;
  logic          r_tok_err;
  logic          r_timeout;

  logic [PW-1:0] w_poll_next;
  logic [7:0]    w_rx;
  logic          w_err_token;

  // One byte of CRC16-CCITT (0x1021), MSB first, folded into a single cycle.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign w_rx        = io_bus.rx_byte;
  assign w_poll_next = r_poll + 1'b1;
  assign w_err_token = (w_rx[7:4] == 4'h0) && (w_rx[3:0] != 4'h0);

  assign io_bus.req_byte = r_req;
  assign io_bus.wr_en    = r_wr_en;
  assign io_bus.wr_addr  = r_wr_addr;
  assign io_bus.wr_data  = r_wr_data;
  assign io_bus.busy     = (r_state != S_IDLE);
  assign io_bus.done     = (r_state == S_FINISH);
  assign io_bus.crc_err  = r_crc_err;
  assign io_bus.tok_err  = r_tok_err;
  assign io_bus.timeout  = r_timeout;

  // Main sequencer: one outstanding byte request at a time, then act on the byte that comes back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_poll     <= '0;
      r_byte_cnt <= '0;
      r_crc      <= '0;
      r_crc_hi   <= '0;
      r_req      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_crc_err  <= 1'b0;
      r_tok_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_req   <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_poll     <= '0;
            r_byte_cnt <= '0;
            r_crc      <= '0;
            r_pend     <= 1'b0;
            r_crc_err  <= 1'b0;
            r_tok_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_state    <= S_WAIT_TOKEN;
          end
        end
        S_WAIT_TOKEN, S_DATA, S_CRC_HI, S_CRC_LO: begin
          if (!r_pend) begin
            // A byte arriving here has no matching request and is dropped.
            r_req  <= 1'b1;
            r_pend <= 1'b1;
          end else if (io_bus.rx_valid) begin
            r_pend <= 1'b0;
            case (r_state)
              S_WAIT_TOKEN: begin
                if (w_rx == 8'hFE) begin
                  r_state <= S_DATA;
                end else if (w_err_token) begin
                  r_tok_err <= 1'b1;
                  r_state   <= S_FINISH;
                end else begin
                  r_poll <= w_poll_next;
                  if (w_poll_next == TO_MAX) begin
                    r_timeout <= 1'b1;
                    r_state   <= S_FINISH;
                  end
                end
              end
              S_DATA: begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_byte_cnt;
                r_wr_data  <= w_rx;
                r_crc      <= crc16_upd(r_crc, w_rx);
                r_byte_cnt <= r_byte_cnt + 9'd1;
                if (r_byte_cnt == LAST_IDX) r_state <= S_CRC_HI;
              end
              S_CRC_HI: begin
                r_crc_hi <= w_rx;
                r_state  <= S_CRC_LO;
              end
              default: begin
                r_crc_err <= ({r_crc_hi, w_rx} != r_crc);
                r_state   <= S_FINISH;
              end
            endcase
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_receiver.sv
// Bench for sd_block_receiver. A card model answers byte requests from a per-block byte list.
// An independent reference computes the expected writes, flags and request count for that list.
module tb_sd_block_receiver;
  localparam int BL = 512;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_block_receiver_if bus();

  sd_block_receiver #(.BLOCK_LEN(BL), .TOKEN_TIMEOUT(TO)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] blk_q[$];
  logic [7:0] exp_data[BL];
  int         e_wr, e_req;
  logic       e_tok, e_to, e_crc;

  int blk_id = 0;
  int spur_req = 0;
  int idle_poke = 0;

  // monitor-owned
  int seen_blk = 0;
  int wr_count = 0, addr_bad = 0, data_bad = 0, done_count = 0, req_count = 0, req_total = 0;
  // responder-owned
  int n_resp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qget(input int i);
    return (i < blk_q.size()) ? blk_q[i] : 8'hFF;
  endfunction

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, by long division on an augmented message.
  function automatic logic [15:0] crc_ref(input logic [7:0] d[BL]);
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < BL; i++)
      for (int b = 7; b >= 0; b--) begin
        r = {r[15:0], d[i][b]};
        if (r[16]) r = r ^ 17'h11021;
      end
    for (int k = 0; k < 16; k++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic model_run();
    int i, polls;
    bit stop, found;
    logic [7:0] b;
    logic [15:0] rcv;
    e_wr = 0; e_tok = 0; e_to = 0; e_crc = 0;
    i = 0; polls = 0; stop = 0; found = 0;
    while (!stop) begin
      b = qget(i); i++; polls++;
      if (b == 8'hFE) begin found = 1; stop = 1; end
      else if (b[7:4] == 4'h0 && b[3:0] != 4'h0) begin e_tok = 1; stop = 1; end
      else if (polls == TO) begin e_to = 1; stop = 1; end
    end
    e_req = polls;
    if (found) begin
      for (int k = 0; k < BL; k++) exp_data[k] = qget(i + k);
      e_wr  = BL;
      rcv   = {qget(i + BL), qget(i + BL + 1)};
      e_crc = (rcv != crc_ref(exp_data));
      e_req = polls + BL + 2;
    end
  endtask

  // Observe outputs on the falling edge; counters restart whenever a new block is announced.
  always @(negedge clk) begin
    if (seen_blk != blk_id) begin
      seen_blk = blk_id;
      wr_count = 0; addr_bad = 0; data_bad = 0; done_count = 0; req_count = 0;
    end
    if (bus.wr_en === 1'b1) begin
      if (wr_count >= BL || int'(bus.wr_addr) != wr_count) addr_bad++;
      else if (bus.wr_data !== exp_data[wr_count]) data_bad++;
      wr_count++;
    end
    if (bus.done === 1'b1) done_count++;
    if (bus.req_byte === 1'b1) begin req_count++; req_total++; end
  end

  // Card / byte-engine model: answers each request after 1..3 cycles.
  // It can hold rx_valid for an extra cycle, and it can send a byte while the receiver is IDLE.
  initial begin
    int rd_idx, resp_blk, spur_done, idle_done;
    rd_idx = 0; resp_blk = 0; spur_done = 0; idle_done = 0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (resp_blk != blk_id) begin resp_blk = blk_id; rd_idx = 0; end
      if (req_total > n_resp) begin
        n_resp++;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.rx_byte  = qget(rd_idx);
        rd_idx++;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        if (spur_done != spur_req) begin
          spur_done    = spur_req;
          bus.rx_byte  = 8'hA5;
          @(negedge clk);
        end
        bus.rx_valid = 1'b0;
      end else if (idle_done != idle_poke) begin
        idle_done    = idle_poke;
        bus.rx_byte  = 8'hFE;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic good_block(input int npoll, input logic [15:0] crc_xor, input bit rnd);
    logic [7:0] d[BL];
    logic [15:0] c;
    blk_q.delete();
    for (int i = 0; i < npoll; i++) blk_q.push_back(8'hFF);
    blk_q.push_back(8'hFE);
    for (int i = 0; i < BL; i++) begin
      d[i] = rnd ? 8'($urandom_range(0, 255)) : 8'hFF;
      blk_q.push_back(d[i]);
    end
    c = crc_ref(d) ^ crc_xor;
    blk_q.push_back(c[15:8]);
    blk_q.push_back(c[7:0]);
  endtask

  task automatic run_block(input string name, input bit mid_start, input bit spur);
    int cyc;
    model_run();
    blk_id++;
    @(negedge clk);
    @(negedge clk);
    pulse_start();
    if (mid_start || spur) begin
      cyc = 0;
      while (wr_count < 50 && cyc < 3000) begin @(negedge clk); cyc++; end
      check({name, "/mid_reached"}, 32'(wr_count >= 50), 32'd1);
      if (mid_start) pulse_start();
      if (spur) spur_req++;
    end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 6000) begin @(negedge clk); cyc++; end
    check({name, "/done_seen"}, bus.done, 1);
    check({name, "/crc_err"}, bus.crc_err, e_crc);
    check({name, "/tok_err"}, bus.tok_err, e_tok);
    check({name, "/timeout"}, bus.timeout, e_to);
    @(negedge clk);
    check({name, "/busy_after"}, bus.busy, 0);
    check({name, "/done_count"}, done_count, 1);
    check({name, "/wr_count"}, wr_count, e_wr);
    check({name, "/addr_bad"}, addr_bad, 0);
    check({name, "/data_bad"}, data_bad, 0);
    check({name, "/req_count"}, req_count, e_req);
  endtask

  initial begin
    int cyc, wc, rc;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/busy", bus.busy, 0);
    check("rst/done", bus.done, 0);
    check("rst/req_byte", bus.req_byte, 0);
    check("rst/wr_en", bus.wr_en, 0);
    check("rst/wr_addr", bus.wr_addr, 0);
    check("rst/wr_data", bus.wr_data, 0);
    check("rst/flags", {bus.crc_err, bus.tok_err, bus.timeout}, 0);
    rst = 1'b0;
    @(negedge clk);

    // byte while IDLE is ignored
    idle_poke++;
    repeat (6) @(negedge clk);
    check("idle_rx/busy", bus.busy, 0);
    check("idle_rx/req", req_total, 0);
    check("idle_rx/wr", wr_count, 0);

    good_block(3, 16'h0000, 0);
    check("good/card_crc", {blk_q[blk_q.size()-2], blk_q[blk_q.size()-1]}, 16'h7FA1);
    run_block("good", 0, 0);

    good_block(3, 16'h0001, 0);
    run_block("badcrc", 0, 0);

    blk_q.delete();
    blk_q.push_back(8'hFF);
    blk_q.push_back(8'h05);
    run_block("tokerr", 0, 0);
    repeat (20) @(negedge clk);
    check("tokerr/hold", bus.tok_err, 1);

    blk_q.delete();
    run_block("timeout", 0, 0);

    good_block(2, 16'h0000, 1);
    run_block("midstart_spur", 1, 1);

    // abort with reset after 100 data bytes, then a full good block
    good_block(1, 16'h0000, 1);
    model_run();
    blk_id++;
    @(negedge clk);
    @(negedge clk);
    pulse_start();
    cyc = 0;
    while (wr_count < 100 && cyc < 3000) begin @(negedge clk); cyc++; end
    check("abort/reached100", wr_count, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort/busy", bus.busy, 0);
    check("abort/wr_en", bus.wr_en, 0);
    check("abort/req_byte", bus.req_byte, 0);
    check("abort/wr_addr", bus.wr_addr, 0);
    check("abort/wr_data", bus.wr_data, 0);
    check("abort/flags", {bus.crc_err, bus.tok_err, bus.timeout}, 0);
    wc = wr_count;
    rc = req_count;
    repeat (20) @(negedge clk);
    check("abort/no_wr", wr_count, wc);
    check("abort/no_req", req_count, rc);
    check("abort/no_done", done_count, 0);
    cyc = 0;
    while ((req_total != n_resp || bus.rx_valid !== 1'b0) && cyc < 50) begin @(negedge clk); cyc++; end
    repeat (4) @(negedge clk);
    run_block("after_abort", 0, 0);

    for (int r = 0; r < 4; r++) begin
      if (r == 3) begin
        blk_q.delete();
        for (int i = 0; i < $urandom_range(0, TO - 2); i++) blk_q.push_back(8'($urandom_range(16, 253)));
        blk_q.push_back(8'($urandom_range(1, 15)));
      end else begin
        good_block(0, 16'h0000, 1);
        blk_q.delete(0);
        for (int i = 0; i < $urandom_range(0, TO - 2); i++)
          blk_q.push_front((i % 2 == 0) ? 8'h00 : 8'($urandom_range(16, 253)));
        if (r == 1) blk_q[blk_q.size()-1] = blk_q[blk_q.size()-1] ^ 8'h80;
        blk_q.push_front(8'hFF);
        blk_q.delete(0);
        // re-insert the start token just before the data
        blk_q.insert(blk_q.size() - BL - 2, 8'hFE);
      end
      run_block($sformatf("rand%0d", r), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
